// File: rtl/tt_um_hang_freqmeter.sv
// Multi-channel gated edge counter (frequency meter) for the TinyTapeout tt_um pinout.
// Optional continuous re-arm from DONE is enabled by defining FM_CONT_EN.
module tt_um_hang_freqmeter #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_BASE   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  // GATE_BASE (max 8192) shifted by gs (max 3) needs 17 bits.
  localparam int TMR_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } state_t;

  state_t                             state;
  logic [SYNC_STAGES-1:0][N_CH-1:0]   sync_q;
  logic [N_CH-1:0]                    hist_q;
  logic [N_CH-1:0]                    edge_vec;
  logic [7:0]                         edge_ext;
  logic                               edge_sel;
  logic                               start_q;
  logic                               start_evt;
  logic [2:0]                         ch_q;
  logic [TMR_W-1:0]                   timer_q;
  logic [TMR_W-1:0]                   gate_len;
  logic [CNT_W-1:0]                   count_q;
  logic [CNT_W-1:0]                   count_next;
  logic                               ovf_q;
  logic                               ovf_next;
  logic [CNT_W-1:0]                   result_q;
  logic [15:0]                        result_ext;
  logic                               done_q;
  logic                               ovf_flag_q;
  logic                               rearm;
  logic                               unused_inputs;

  // Synchroniser chain plus one history flop per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync_q[0] <= ui_in[N_CH-1:0];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_vec = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Channels at or above N_CH read as a constant zero edge.
  always_comb begin
    // NOTE: default first so no path through this block leaves a variable unassigned (no latch).
    edge_ext = '0;
    edge_ext[N_CH-1:0] = edge_vec;
  end

  assign edge_sel  = edge_ext[ch_q];
  assign start_evt = ena & uio_in[3] & ~start_q;
  assign gate_len  = TMR_W'(GATE_BASE) << uio_in[5:4];

  // Saturating count; an edge arriving at full scale raises overflow instead.
  always_comb begin
    count_next = count_q;
    ovf_next   = ovf_q;
    if (edge_sel) begin
      if (&count_q) ovf_next = 1'b1;
      else          count_next = count_q + CNT_W'(1);
    end
  end

`ifdef FM_CONT_EN
  assign rearm = start_evt | uio_in[7];
`else
  assign rearm = start_evt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      ch_q       <= '0;
      timer_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      start_q <= uio_in[3];
      case (state)
        IDLE: begin
          if (start_evt) begin
            state      <= ARM;
            done_q     <= 1'b0;
            ovf_flag_q <= 1'b0;
          end
        end
        ARM: begin
          ch_q    <= uio_in[2:0];
          timer_q <= gate_len;
          count_q <= '0;
          ovf_q   <= 1'b0;
          state   <= GATE;
        end
        GATE: begin
          count_q <= count_next;
          ovf_q   <= ovf_next;
          timer_q <= timer_q - TMR_W'(1);
          // Final gate cycle: its edge is folded into the latched result.
          if (timer_q == TMR_W'(1)) begin
            state      <= DONE;
            result_q   <= count_next;
            ovf_flag_q <= ovf_next;
            done_q     <= 1'b1;
          end
        end
        DONE: begin
          if (rearm) begin
            state      <= ARM;
            done_q     <= 1'b0;
            ovf_flag_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result_ext = 16'(result_q);
  assign uo_out     = uio_in[6] ? result_ext[15:8] : result_ext[7:0];
  assign uio_out    = {done_q, ovf_flag_q, 6'b0};
  assign uio_oe     = 8'hC0;

  // Upper ui_in bits and, in single-shot builds, uio_in[7] carry no function.
  assign unused_inputs = ^{ui_in, uio_in};

endmodule

// File: tb/tb_tt_um_hang_freqmeter.sv
// Randomised bench for tt_um_hang_freqmeter: a 16-bit and an 8-bit counter instance
// share stimulus and are checked against an edge-count model built from the pin history.
module tb_tt_um_hang_freqmeter;
  localparam int N_CH = 4;
  localparam int SYNC = 2;
  localparam int BASE = 256;
  localparam int LOG_N = 100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out,  uio_out,  uio_oe;
  logic [7:0] uo_out8, uio_out8, uio_oe8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int half [8];
  logic [7:0] pin_log [0:LOG_N-1];

  always #5 clk = ~clk;

  tt_um_hang_freqmeter #(.N_CH(N_CH), .CNT_W(16), .GATE_BASE(BASE), .SYNC_STAGES(SYNC)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  tt_um_hang_freqmeter #(.N_CH(N_CH), .CNT_W(8), .GATE_BASE(BASE), .SYNC_STAGES(SYNC)) dut8 (
    .ui_in(ui_in), .uo_out(uo_out8), .uio_in(uio_in), .uio_out(uio_out8),
    .uio_oe(uio_oe8), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  // Pin level seen at each rising edge, indexed by edge number.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < LOG_N) pin_log[cyc] = ui_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_pins();
    for (int i = 0; i < 8; i++) begin
      if (half[i] == 0)             ui_in[i] = 1'($urandom % 2);
      else if (cyc % half[i] == 0)  ui_in[i] = ~ui_in[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_pins();
  endtask

  // Rising edges on the pin, delayed by the synchroniser latency, that land in gate cycles.
  function automatic int exp_count(input int s, input int g, input int ch);
    int n = 0;
    if (ch >= N_CH) return 0;
    for (int p = s + 2; p <= s + g + 1; p++) begin
      if (pin_log[p-SYNC][ch] && !pin_log[p-SYNC-1][ch]) n++;
    end
    return n;
  endfunction

  task automatic read_result(output logic [15:0] r, output logic [15:0] r8);
    uio_in[6] = 1'b0; #1;
    r[7:0] = uo_out; r8[7:0] = uo_out8;
    uio_in[6] = 1'b1; #1;
    r[15:8] = uo_out; r8[15:8] = uo_out8;
    uio_in[6] = 1'b0; #1;
  endtask

  task automatic check_result(input string tag, input int ex);
    logic [15:0] r, r8;
    read_result(r, r8);
    check({tag, "_res16"}, r, ex);
    check({tag, "_res8"}, r8, (ex > 255) ? 255 : ex);
    check({tag, "_ovf16"}, uio_out[6], 0);
    check({tag, "_ovf8"}, uio_out8[6], (ex > 255) ? 1 : 0);
  endtask

  task automatic run_window(input string tag, input int ch, input int gs, input bit mid_start,
                            input bit drop_ena, output int ex);
    int g = BASE << gs;
    int s;
    uio_in[2:0] = 3'(ch);
    uio_in[5:4] = 2'(gs);
    uio_in[3]   = 1'b0;
    tick(); tick();
    uio_in[3] = 1'b1;
    tick();
    s = cyc;
    uio_in[3] = 1'b0;
    check({tag, "_arm_flags16"}, uio_out[7:6], 0);
    check({tag, "_arm_flags8"}, uio_out8[7:6], 0);
    for (int k = 1; k <= g; k++) begin
      tick();
      if (k == g / 2) begin
        if (mid_start) uio_in[3] = 1'b1;
        if (drop_ena)  ena = 1'b0;
      end
      if (k == g / 2 + 1) uio_in[3] = 1'b0;
      if (k == g) check({tag, "_done_early"}, uio_out[7], 0);
    end
    tick();
    ena = 1'b1;
    check({tag, "_done16"}, uio_out[7], 1);
    check({tag, "_done8"}, uio_out8[7], 1);
    ex = exp_count(s, g, ch);
    check_result(tag, ex);
  endtask

  initial begin
    int ex;
    logic [15:0] r, r8;
    for (int i = 0; i < 8; i++) half[i] = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);

    // Reset with random inputs.
    for (int i = 0; i < 5; i++) begin
      tick();
      uio_in = 8'($urandom);
    end
    check("rst_uo", uo_out, 0);
    check("rst_uio", uio_out, 0);
    check("rst_oe", uio_oe, 8'hC0);
    uio_in = 8'h00;
    rst_n  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_uio", uio_out, 0);
    check("post_rst_uo", uo_out, 0);

    // Basic count: ch0 period 4, others random.
    half[0] = 2;
    run_window("basic", 0, 0, 1'b0, 1'b0, ex);

    // Gate scaling, channel select, start ignored mid-gate.
    for (int i = 0; i < 8; i++) half[i] = 1;
    half[2] = 4;
    run_window("scale", 2, 2, 1'b1, 1'b0, ex);

    // Saturation of the 8-bit instance, then next start clears flags in ARM.
    for (int i = 0; i < 8; i++) half[i] = 0;
    half[0] = 1;
    run_window("sat", 0, 3, 1'b0, 1'b0, ex);
    check("sat_ovf_seen", uio_out8[6], 1);
    half[0] = 3;
    run_window("after_sat", 0, 0, 1'b0, 1'b0, ex);

    // Unimplemented channel counts nothing.
    half[1] = 1;
    run_window("ch5", 5, 0, 1'b0, 1'b0, ex);

    // Start with ena low is ignored; result held.
    half[1] = 2;
    run_window("hold", 1, 0, 1'b0, 1'b0, ex);
    ena = 1'b0;
    uio_in[3] = 1'b1; tick();
    uio_in[3] = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    ena = 1'b1;
    check("ena_low_done", uio_out[7], 1);
    check_result("ena_low", ex);

    // ena dropped mid-gate still completes.
    run_window("ena_drop", 1, 1, 1'b0, 1'b1, ex);

    // Reset mid-gate aborts everything.
    uio_in[2:0] = 3'd0; uio_in[5:4] = 2'd1;
    uio_in[3] = 1'b1; tick();
    uio_in[3] = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_uo", uo_out, 0);
    check("midrst_uio", uio_out, 0);
    check("midrst_oe", uio_oe, 8'hC0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) tick();
    check("midrst_done", uio_out[7], 0);
    read_result(r, r8);
    check("midrst_res", r, 0);

`ifdef FM_CONT_EN
    begin
      int s;
      int g = BASE;
      for (int i = 0; i < 8; i++) half[i] = 0;
      half[0] = 2;
      uio_in = 8'h80;
      uio_in[3] = 1'b1; tick();
      s = cyc;
      uio_in[3] = 1'b0;
      for (int w = 0; w < 3; w++) begin
        while (cyc < s + g) tick();
        check("cont_pre_done", uio_out[7], 0);
        if (w == 2) uio_in[7] = 1'b0;
        tick();
        check("cont_done", uio_out[7], 1);
        check_result("cont", exp_count(s, g, 0));
        tick();
        check("cont_after", uio_out[7], (w == 2) ? 1 : 0);
        s = s + g + 2;
      end
      for (int i = 0; i < g + 10; i++) tick();
      check("cont_stopped", uio_out[7], 1);
    end
`else
    // Continuous request is inert in single-shot builds.
    run_window("single", 0, 0, 1'b0, 1'b0, ex);
    uio_in[7] = 1'b1;
    for (int i = 0; i < BASE + 10; i++) tick();
    check("single_held", uio_out[7], 1);
    check_result("single_held", ex);
    uio_in[7] = 1'b0;
`endif

    // Random channels, gates and pin waveforms.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 8; i++) half[i] = $urandom_range(0, 5);
      run_window("rand", $urandom_range(0, 7), $urandom_range(0, 1), 1'($urandom % 2),
                 1'($urandom % 2), ex);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
